sb_ms_timer: RTL and testbench

//  Millisecond timeout timer for the sideband / lane-training control path. Sits directly

---
 rtl/usb4_timer_pkg.sv | 22 ++
 rtl/ms_tick_det.sv | 31 +++
 rtl/sb_ms_timer.sv | 164 ++++++++++++++++
 tb/tb_sb_ms_timer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb4_timer_pkg.sv
// ----------------------------------------------------------------------------
// usb4_timer_pkg
//   Shared definitions for the sideband millisecond timer and the lane-training
//   FSM that drives it: timer state names, default counter width and the
//   default preset limits (in ms ticks).
// ----------------------------------------------------------------------------
package usb4_timer_pkg;

    // Timer state; encoding 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EXPD = 2'd2
    } tmr_state_t;

    localparam int unsigned CNT_W_DEF = 10;
    localparam int unsigned T0_MS_DEF = 10;
    localparam int unsigned T1_MS_DEF = 50;
    localparam int unsigned T2_MS_DEF = 100;
    localparam int unsigned T3_MS_DEF = 500;

endpackage

// File: rtl/ms_tick_det.sv
// ----------------------------------------------------------------------------
// ms_tick_det
//   Turns every edge (rising or falling) of the divided ms clock into a
//   one-cycle tick in the sideband clock domain. ms_clk is already synchronous
//   to i_clk, so the tick is the XOR of ms_clk with its registered copy.
// Ports
//   i_clk     sideband clock
//   i_rst_n   asynchronous active-low reset
//   i_ms_clk  divided ms clock (synchronous to i_clk)
//   o_tick    high for one cycle after each ms_clk edge
// ----------------------------------------------------------------------------
module ms_tick_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ms_clk,
    output logic o_tick
);

    logic r_ms_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ms_prev <= 1'b0;
        end else begin
            r_ms_prev <= i_ms_clk;
        end
    end

    assign o_tick = i_ms_clk ^ r_ms_prev;

endmodule

// File: rtl/sb_ms_timer.sv
// ----------------------------------------------------------------------------
// sb_ms_timer
//   Millisecond timeout timer for the sideband / lane-training control path.
//   Counts ms ticks (both edges of ms_clk) after a start request and reports
//   expiry when the selected preset limit is reached.
// Ports
//   sb_clk       sideband clock, the only clock
//   rst          asynchronous active-low reset
//   ms_clk       divided ms clock; each edge is one tick
//   tmr_start    1-cycle request: load preset tmr_sel and (re)start
//   tmr_stop     1-cycle request: abort and return to IDLE
//   tmr_sel      preset select, sampled with tmr_start
//   tmr_busy     high while running
//   tmr_expired  1-cycle expiry pulse
//   tmr_timeout  sticky expiry flag, cleared by tmr_start or reset
//   tmr_elapsed  ticks counted since the last start (saturating)
// ----------------------------------------------------------------------------
module sb_ms_timer
    import usb4_timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned T0_MS = T0_MS_DEF,
    parameter int unsigned T1_MS = T1_MS_DEF,
    parameter int unsigned T2_MS = T2_MS_DEF,
    parameter int unsigned T3_MS = T3_MS_DEF
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             ms_clk,
    input  logic             tmr_start,
    input  logic             tmr_stop,
    input  logic [1:0]       tmr_sel,
    output logic             tmr_busy,
    output logic             tmr_expired,
    output logic             tmr_timeout,
    output logic [CNT_W-1:0] tmr_elapsed
);

    localparam int unsigned      MAX_LIM = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] L_T0    = CNT_W'(T0_MS);
    localparam logic [CNT_W-1:0] L_T1    = CNT_W'(T1_MS);
    localparam logic [CNT_W-1:0] L_T2    = CNT_W'(T2_MS);
    localparam logic [CNT_W-1:0] L_T3    = CNT_W'(T3_MS);
    localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_SAT   = '1;

    // Preset limits must be representable and non-zero.
    if ((T0_MS < 1) || (T0_MS > MAX_LIM)) begin : g_bad_t0
        $error("sb_ms_timer: T0_MS out of range 1..2**CNT_W-1");
    end
    if ((T1_MS < 1) || (T1_MS > MAX_LIM)) begin : g_bad_t1
        $error("sb_ms_timer: T1_MS out of range 1..2**CNT_W-1");
    end
    if ((T2_MS < 1) || (T2_MS > MAX_LIM)) begin : g_bad_t2
        $error("sb_ms_timer: T2_MS out of range 1..2**CNT_W-1");
    end
    if ((T3_MS < 1) || (T3_MS > MAX_LIM)) begin : g_bad_t3
        $error("sb_ms_timer: T3_MS out of range 1..2**CNT_W-1");
    end

    tmr_state_t       r_state;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_elapsed;
    logic             r_busy;
    logic             r_expired;
    logic             r_timeout;

    logic             w_tick;
    logic [CNT_W-1:0] w_sel_limit;
    logic [CNT_W-1:0] w_limit_eff;
    logic [CNT_W-1:0] w_elapsed_inc;
    logic             w_hit;

    ms_tick_det u_tick_det (
        .i_clk    (sb_clk),
        .i_rst_n  (rst),
        .i_ms_clk (ms_clk),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_sel_limit = L_T0;
        case (tmr_sel)
            2'b00:   w_sel_limit = L_T0;
            2'b01:   w_sel_limit = L_T1;
            2'b10:   w_sel_limit = L_T2;
            default: w_sel_limit = L_T3;
        endcase
    end

    // A zero limit (only reachable out of reset) behaves as a 1-tick timeout.
    assign w_limit_eff   = (r_limit == '0) ? L_ONE : r_limit;
    assign w_elapsed_inc = (r_elapsed == L_SAT) ? L_SAT : (r_elapsed + L_ONE);
    // A saturated count must not alias onto a limit of all-ones.
    assign w_hit         = (r_elapsed != L_SAT) && (w_elapsed_inc == w_limit_eff);

    // Start has top priority in every state; in EXPD the pulse already on the
    // output still completes while the timer reloads.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_limit   <= '0;
            r_elapsed <= '0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tmr_start) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_limit   <= w_sel_limit;
                        r_elapsed <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (tmr_start) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_limit   <= w_sel_limit;
                        r_elapsed <= '0;
                        r_timeout <= 1'b0;
                    end else if (tmr_stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_elapsed <= w_elapsed_inc;
                        if (w_hit) begin
                            r_state   <= EXPD;
                            r_busy    <= 1'b0;
                            r_expired <= 1'b1;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                EXPD: begin
                    if (tmr_start) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_limit   <= w_sel_limit;
                        r_elapsed <= '0;
                        r_timeout <= 1'b0;
                    end else begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tmr_busy    = r_busy;
    assign tmr_expired = r_expired;
    assign tmr_timeout = r_timeout;
    assign tmr_elapsed = r_elapsed;

endmodule

// File: tb/tb_sb_ms_timer.sv
// ----------------------------------------------------------------------------
// tb_sb_ms_timer
//   Self-checking bench for sb_ms_timer with presets 3/5/7/9 ticks. ms_clk
//   toggles every 1000 sb_clk cycles. A behavioural model (active flag, tick
//   count since start, sticky timeout) is compared against the DUT on every
//   falling edge; directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_sb_ms_timer;

    localparam int unsigned CNT_W = 10;
    localparam int          PRESET [4] = '{3, 5, 7, 9};
    localparam int          SAT = (1 << CNT_W) - 1;

    logic             sb_clk = 1'b0;
    logic             rst = 1'b1;
    logic             ms_clk = 1'b0;
    logic             tmr_start = 1'b0;
    logic             tmr_stop = 1'b0;
    logic [1:0]       tmr_sel = 2'b00;
    logic             tmr_busy;
    logic             tmr_expired;
    logic             tmr_timeout;
    logic [CNT_W-1:0] tmr_elapsed;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned ms_phase = 0;
    int unsigned ntog     = 0;

    // behavioural model state
    bit m_prev   = 1'b0;
    bit m_active = 1'b0;
    bit m_exp    = 1'b0;
    bit m_to     = 1'b0;
    int m_count  = 0;
    int m_limit  = 0;

    sb_ms_timer #(
        .CNT_W (CNT_W),
        .T0_MS (3),
        .T1_MS (5),
        .T2_MS (7),
        .T3_MS (9)
    ) dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .ms_clk      (ms_clk),
        .tmr_start   (tmr_start),
        .tmr_stop    (tmr_stop),
        .tmr_sel     (tmr_sel),
        .tmr_busy    (tmr_busy),
        .tmr_expired (tmr_expired),
        .tmr_timeout (tmr_timeout),
        .tmr_elapsed (tmr_elapsed)
    );

    always #5 sb_clk = ~sb_clk;

    // Divider stand-in: ms_clk toggles every 1000 sb_clk cycles.
    initial begin
        forever begin
            @(posedge sb_clk);
            #2;
            if (ms_phase == 999) begin
                ms_clk   = ~ms_clk;
                ms_phase = 0;
                ntog     = ntog + 1;
            end else begin
                ms_phase = ms_phase + 1;
            end
        end
    end

    // Model: a tick is any change of ms_clk seen between two clock edges.
    // While active, ticks are counted; reaching the limit ends the run with a
    // one-cycle expiry and a sticky timeout. Start always restarts.
    always @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            m_prev   <= 1'b0;
            m_active <= 1'b0;
            m_exp    <= 1'b0;
            m_to     <= 1'b0;
            m_count  <= 0;
            m_limit  <= 0;
        end else begin
            m_prev <= ms_clk;
            m_exp  <= 1'b0;
            if (tmr_start) begin
                m_active <= 1'b1;
                m_count  <= 0;
                m_limit  <= PRESET[tmr_sel];
                m_to     <= 1'b0;
            end else if (m_active && tmr_stop) begin
                m_active <= 1'b0;
            end else if (m_active && (ms_clk != m_prev)) begin
                m_count <= (m_count == SAT) ? m_count : m_count + 1;
                if (m_count + 1 == m_limit) begin
                    m_active <= 1'b0;
                    m_exp    <= 1'b1;
                    m_to     <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sb_clk) begin
        chk("cyc_busy",    int'(tmr_busy),    int'(m_active));
        chk("cyc_expired", int'(tmr_expired), int'(m_exp));
        chk("cyc_timeout", int'(tmr_timeout), int'(m_to));
        chk("cyc_elapsed", int'(tmr_elapsed), m_count);
    end

    // Caller sits at a falling edge; returns at the next falling edge.
    task automatic pulse_start(input logic [1:0] sel, input logic with_stop);
        tmr_start = 1'b1;
        tmr_stop  = with_stop;
        tmr_sel   = sel;
        @(negedge sb_clk);
        tmr_start = 1'b0;
        tmr_stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        tmr_stop = 1'b1;
        @(negedge sb_clk);
        tmr_stop = 1'b0;
    endtask

    task automatic wait_tog(input string name, input int unsigned tog0,
                            input int unsigned n, input int unsigned ph);
        bit hit = 1'b0;
        for (int k = 0; k < 20000 && !hit; k++) begin
            if ((ntog - tog0 == n) && (ms_phase == ph)) hit = 1'b1;
            else @(negedge sb_clk);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: wait expired, actual=no tick expected=tick %0d", name, n);
        end
    endtask

    task automatic wait_expired(input string name);
        bit hit = 1'b0;
        for (int k = 0; k < 12000 && !hit; k++) begin
            if (tmr_expired) hit = 1'b1;
            else @(negedge sb_clk);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: wait expired, actual=no pulse expected=tmr_expired", name);
        end
    endtask

    int unsigned tog0;
    int unsigned gap;
    int unsigned act;

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge sb_clk);
        chk("rst_busy",    int'(tmr_busy),    0);
        chk("rst_elapsed", int'(tmr_elapsed), 0);
        rst = 1'b1;
        @(negedge sb_clk);
        chk("rel_busy",    int'(tmr_busy),    0);
        chk("rel_timeout", int'(tmr_timeout), 0);

        // 1: preset 0 (3 ticks), start shortly before a toggle
        while (ms_phase != 989) @(negedge sb_clk);
        tog0 = ntog;
        pulse_start(2'b00, 1'b0);
        chk("t1_busy_rise", int'(tmr_busy), 1);
        wait_expired("t1_expire");
        chk("t1_ticks",   int'(ntog - tog0),  3);
        chk("t1_phase",   int'(ms_phase),     1);
        chk("t1_elapsed", int'(tmr_elapsed),  3);
        chk("t1_timeout", int'(tmr_timeout),  1);
        chk("t1_busy",    int'(tmr_busy),     0);
        @(negedge sb_clk);
        chk("t1_pulse_end", int'(tmr_expired), 0);

        // 2: preset 3, stop after tick 4
        tog0 = ntog;
        pulse_start(2'b11, 1'b0);
        wait_tog("t2_wait", tog0, 4, 1);
        chk("t2_elapsed4", int'(tmr_elapsed), 4);
        pulse_stop();
        chk("t2_busy",    int'(tmr_busy),    0);
        chk("t2_elapsed", int'(tmr_elapsed), 4);
        chk("t2_expired", int'(tmr_expired), 0);
        chk("t2_timeout", int'(tmr_timeout), 0);

        // 3: preset 1 at elapsed 2, restart with preset 0
        tog0 = ntog;
        pulse_start(2'b01, 1'b0);
        wait_tog("t3_wait", tog0, 2, 1);
        chk("t3_elapsed2", int'(tmr_elapsed), 2);
        tog0 = ntog;
        pulse_start(2'b00, 1'b0);
        chk("t3_restart", int'(tmr_elapsed), 0);
        wait_expired("t3_expire");
        chk("t3_ticks", int'(ntog - tog0), 3);
        @(negedge sb_clk);

        // 4: start+stop from IDLE, then start on the final tick
        tog0 = ntog;
        pulse_start(2'b00, 1'b1);
        chk("t4_busy", int'(tmr_busy), 1);
        wait_tog("t4_wait", tog0, 3, 0);
        pulse_start(2'b00, 1'b0);
        chk("t4_no_exp", int'(tmr_expired), 0);
        chk("t4_elapsed", int'(tmr_elapsed), 0);
        chk("t4_busy2", int'(tmr_busy), 1);
        pulse_stop();

        // 5: asynchronous reset mid-run
        tog0 = ntog;
        pulse_start(2'b11, 1'b0);
        wait_tog("t5_wait", tog0, 2, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_busy",    int'(tmr_busy),    0);
        chk("t5_elapsed", int'(tmr_elapsed), 0);
        chk("t5_expired", int'(tmr_expired), 0);
        chk("t5_timeout", int'(tmr_timeout), 0);
        @(negedge sb_clk);
        while (ms_phase != 999) @(negedge sb_clk);
        rst = 1'b1;
        tog0 = ntog;
        wait_tog("t5_idle_wait", tog0, 1, 2);
        chk("t5_idle_elapsed", int'(tmr_elapsed), 0);
        chk("t5_idle_busy",    int'(tmr_busy),    0);

        // 6: start during the expiry cycle
        pulse_start(2'b00, 1'b0);
        wait_expired("t6_expire");
        chk("t6_timeout_set", int'(tmr_timeout), 1);
        pulse_start(2'b01, 1'b0);
        chk("t6_expired", int'(tmr_expired), 0);
        chk("t6_timeout", int'(tmr_timeout), 0);
        chk("t6_busy",    int'(tmr_busy),    1);
        chk("t6_elapsed", int'(tmr_elapsed), 0);
        pulse_stop();

        // randomized requests, sometimes aligned to a tick
        for (int i = 0; i < 14; i++) begin
            gap = $urandom_range(100, 2500);
            repeat (gap) @(negedge sb_clk);
            if ($urandom_range(0, 2) == 0) begin
                while (ms_phase != 0) @(negedge sb_clk);
            end
            act = $urandom_range(0, 3);
            case (act)
                0, 1:    pulse_start(2'($urandom_range(0, 3)), 1'b0);
                2:       pulse_stop();
                default: pulse_start(2'($urandom_range(0, 3)), 1'b1);
            endcase
        end
        repeat (3000) @(negedge sb_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
